// File: rtl/db_pkg.sv
// Shared constants and types for the KV key extractor: header match values,
// op flags and the parser state encoding.
package db_pkg;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VIHL_5     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
   localparam logic [3:0]  FLAG_LOOKUP   = 4'h1;
   localparam logic [3:0]  FLAG_INSERT   = 4'h2;
   localparam int          KEY_SIZE      = 96;
   localparam int          FLAG_SIZE     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      SKIP = 2'd2
   } state_t;
endpackage

// File: rtl/db_key_extract_if.sv
// RX tap stream plus DB key handshake. Stream beats move on tvalid && tready;
// a key moves on key_valid, which is only raised while key_ready is high.
interface db_key_extract_if;
   import db_pkg::*;

   logic [63:0]           s_axis_tdata;
   logic [7:0]            s_axis_tkeep;
   logic                  s_axis_tvalid;
   logic                  s_axis_tlast;
   logic                  s_axis_tready;
   logic [KEY_SIZE-1:0]   key_out;
   logic [FLAG_SIZE-1:0]  flag_out;
   logic                  key_valid;
   logic                  key_ready;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, key_ready,
      input  s_axis_tready, key_out, flag_out, key_valid
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, key_ready,
      output s_axis_tready, key_out, flag_out, key_valid
   );
endinterface

// File: rtl/db_key_fifo.sv
// Synchronous FIFO with wrapping extra-bit pointers. A push while full is
// accepted only when a pop frees the head slot on the same edge.
module db_key_fifo #(
   parameter int W     = 100,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_q, rd_q;
   logic         wr_en, rd_en;

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign rdata_o = mem[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (rd_en) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/db_key_extract.sv
// Passive Ethernet/IPv4/UDP header parser: builds a {srcIP,dstIP,dstPort,0}
// key per qualifying frame and queues it for the DB lookup stage.
module db_key_extract
   import db_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] WATCH_PORT = 16'd53,
   parameter int          KEY_SIZE   = 96,
   parameter int          FLAG_SIZE  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   db_key_extract_if.slave      bus,
   output logic [31:0]          stat_frames,
   output logic [31:0]          stat_keys,
   output logic [31:0]          stat_drops,
   output state_t               dbg_state_o
);
   state_t                 state_q;
   logic                   tready_q;
   logic [2:0]             beat_q;
   logic [31:0]            sip_q;
   logic [15:0]            dip_hi_q;
   logic                   push_q;
   logic [KEY_SIZE-1:0]    key_q;
   logic [FLAG_SIZE-1:0]   flag_q;
   logic [31:0]            frames_q, keys_q, drops_q;

   logic                   beat, last;
   logic [63:0]            d;
   logic [7:0]             keep;
   logic                   b1_ok, b2_ok, b3_ok, b4_ok;
   logic [15:0]            src_port;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [KEY_SIZE+FLAG_SIZE-1:0] fifo_rdata;

   assign d        = bus.s_axis_tdata;
   assign keep     = bus.s_axis_tkeep;
   assign beat     = bus.s_axis_tvalid && tready_q;
   assign last     = bus.s_axis_tlast;
   assign src_port = {d[23:16], d[31:24]};

   // Wire order is byte 0 in [7:0], so multi-byte fields are byte-swapped here.
   assign b1_ok = ({d[39:32], d[47:40]} == ETH_TYPE_IPV4) && (d[55:48] == IP_VIHL_5) && (&keep);
   assign b2_ok = (d[63:56] == IP_PROTO_UDP) && (&keep);
   assign b3_ok = &keep;
   assign b4_ok = &keep[5:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tready_q <= 1'b0;
         beat_q   <= '0;
         sip_q    <= '0;
         dip_hi_q <= '0;
         push_q   <= 1'b0;
         key_q    <= '0;
         flag_q   <= '0;
         frames_q <= '0;
         keys_q   <= '0;
         drops_q  <= '0;
      end else begin
         tready_q <= 1'b1;
         push_q   <= 1'b0;
         if (beat) begin
            beat_q <= last ? 3'd0 : ((beat_q == 3'd4) ? 3'd4 : beat_q + 3'd1);
            case (state_q)
               IDLE: state_q <= HDR;
               HDR: begin
                  case (beat_q)
                     3'd1: if (!b1_ok) state_q <= SKIP;
                     3'd2: if (!b2_ok) state_q <= SKIP;
                     3'd3: begin
                        sip_q    <= {d[23:16], d[31:24], d[39:32], d[47:40]};
                        dip_hi_q <= {d[55:48], d[63:56]};
                        if (!b3_ok) state_q <= SKIP;
                     end
                     default: begin
                        if (b4_ok) begin
                           push_q <= 1'b1;
                           key_q  <= {sip_q, dip_hi_q, d[7:0], d[15:8], d[39:32], d[47:40], 16'h0000};
                           flag_q <= (src_port == WATCH_PORT) ? FLAG_INSERT : FLAG_LOOKUP;
                        end
                        state_q <= SKIP;
                     end
                  endcase
               end
               default: state_q <= SKIP;
            endcase
            if (last) begin
               state_q  <= IDLE;
               frames_q <= frames_q + 32'd1;
            end
         end
         // A full FIFO still takes the key if the DB drains the head this cycle.
         if (push_q) begin
            if (!fifo_full || fifo_pop) keys_q  <= keys_q + 32'd1;
            else                        drops_q <= drops_q + 32'd1;
         end
      end
   end

   assign fifo_pop = !fifo_empty && bus.key_ready;

   db_key_fifo #(
      .W     (KEY_SIZE + FLAG_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_q),
      .pop_i   (fifo_pop),
      .wdata_i ({flag_q, key_q}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.s_axis_tready = tready_q;
   assign bus.key_valid     = fifo_pop;
   assign bus.key_out       = fifo_empty ? '0 : fifo_rdata[KEY_SIZE-1:0];
   assign bus.flag_out      = fifo_empty ? '0 : fifo_rdata[KEY_SIZE+FLAG_SIZE-1:KEY_SIZE];
   assign stat_frames       = frames_q;
   assign stat_keys         = keys_q;
   assign stat_drops        = drops_q;
   assign dbg_state_o       = state_q;
endmodule
